// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle between a requester (master) and the serial
// binary-to-BCD converter (slave).
interface bin_to_bcd_seq_if #(
    parameter int BIN_W  = 32,
    parameter int DIGITS = 10
);
    logic                  start;
    logic                  signed_mode;
    logic [BIN_W-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic [DIGITS-1:0]     en;
    logic                  neg;
    logic                  overflow;

    modport master (
        output start, signed_mode, bin,
        input  busy, done, bcd, en, neg, overflow
    );

    modport slave (
        input  start, signed_mode, bin,
        output busy, done, bcd, en, neg, overflow
    );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Serial double-dabble binary-to-BCD converter, one bit per clock, with
// signed input, overflow saturation and a leading-zero blanking mask.
module bin_to_bcd_seq #(
    parameter int BIN_W  = 32,
    parameter int DIGITS = 10,
    parameter int CNT_W  = $clog2(BIN_W + 1)
) (
    input  logic            clk_100kHz,
    input  logic            rst_,
    bin_to_bcd_seq_if.slave bus
);
    localparam int                ACC_W   = 4 * DIGITS;
    localparam logic [BIN_W-1:0]  MAG_ONE = BIN_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [BIN_W-1:0]    mag_q, mag_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [ACC_W-1:0]    acc_adj;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                neg_int_q, neg_int_d;
    logic                sticky_q, sticky_d;
    logic                done_q, done_d;
    logic [ACC_W-1:0]    bcd_q, bcd_d;
    logic [DIGITS-1:0]   en_q, en_d;
    logic                neg_q, neg_d;
    logic                ovf_q, ovf_d;

    // Digit i is lit when it or any more significant digit is nonzero.
    function automatic logic [DIGITS-1:0] digit_enables(input logic [ACC_W-1:0] digits);
        logic [DIGITS-1:0] mask;
        logic              seen;
        mask = '0;
        seen = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            seen    = seen | (digits[4*i +: 4] != 4'd0);
            mask[i] = seen;
        end
        mask[0] = 1'b1;
        return mask;
    endfunction

    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_d   = state_q;
        mag_d     = mag_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_int_d = neg_int_q;
        sticky_d  = sticky_q;
        done_d    = 1'b0;
        bcd_d     = bcd_q;
        en_d      = en_q;
        neg_d     = neg_q;
        ovf_d     = ovf_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = SHIFT;
                    neg_int_d = bus.signed_mode && bus.bin[BIN_W-1];
                    mag_d     = (bus.signed_mode && bus.bin[BIN_W-1]) ? (~bus.bin + MAG_ONE) : bus.bin;
                    acc_d     = '0;
                    sticky_d  = 1'b0;
                    cnt_d     = CNT_W'(BIN_W);
                end
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    // A bit leaving the top digit means the value no longer fits.
                    sticky_d = sticky_q | acc_adj[ACC_W-1];
                    acc_d    = {acc_adj[ACC_W-2:0], mag_q[BIN_W-1]};
                    mag_d    = {mag_q[BIN_W-2:0], 1'b0};
                    cnt_d    = cnt_q - CNT_ONE;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    neg_d   = neg_int_q;
                    ovf_d   = sticky_q;
                    bcd_d   = sticky_q ? {DIGITS{4'h9}} : acc_q;
                    en_d    = sticky_q ? '1 : digit_enables(acc_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values computed above, independent of statement order.
    always_ff @(posedge clk_100kHz) begin
        if (!rst_) begin
            state_q   <= IDLE;
            mag_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_int_q <= 1'b0;
            sticky_q  <= 1'b0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
            en_q      <= DIGITS'(1);
            neg_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mag_q     <= mag_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_int_q <= neg_int_d;
            sticky_q  <= sticky_d;
            done_q    <= done_d;
            bcd_q     <= bcd_d;
            en_q      <= en_d;
            neg_q     <= neg_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.busy     = (state_q == SHIFT);
    assign bus.done     = done_q;
    assign bus.bcd      = bcd_q;
    assign bus.en       = en_q;
    assign bus.neg      = neg_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: a 32-bit/10-digit and a 16-bit/4-digit instance
// checked every cycle against an arithmetic reference model.
`timescale 1ns/1ps
module tb_bin_to_bcd_seq;
    logic clk_100kHz = 1'b0;
    logic rst_       = 1'b0;
    always #5 clk_100kHz = ~clk_100kHz;

    int tests = 0;
    int fails = 0;

    bin_to_bcd_seq_if #(.BIN_W(32), .DIGITS(10)) if32 ();
    bin_to_bcd_seq_if #(.BIN_W(16), .DIGITS(4))  if16 ();

    bin_to_bcd_seq #(.BIN_W(32), .DIGITS(10)) u_dut32 (
        .clk_100kHz (clk_100kHz),
        .rst_       (rst_),
        .bus        (if32.slave)
    );

    bin_to_bcd_seq #(.BIN_W(16), .DIGITS(4)) u_dut16 (
        .clk_100kHz (clk_100kHz),
        .rst_       (rst_),
        .bus        (if16.slave)
    );

    // Reference model state, index 0 = 32-bit instance, 1 = 16-bit instance.
    bit          model_live = 1'b0;
    int          m_cnt  [2];
    bit          m_done [2];
    logic [63:0] m_bcd  [2];
    logic [63:0] m_en   [2];
    bit          m_neg  [2];
    bit          m_ovf  [2];
    logic [63:0] m_pbcd [2];
    logic [63:0] m_pen  [2];
    bit          m_pneg [2];
    bit          m_povf [2];

    function automatic int bw_of(input int k);
        return (k == 0) ? 32 : 16;
    endfunction

    function automatic int nd_of(input int k);
        return (k == 0) ? 10 : 4;
    endfunction

    function automatic logic [63:0] mask_of(input int bw);
        return (64'd1 << bw) - 64'd1;
    endfunction

    function automatic bit busy_of(input int k);
        return (k == 0) ? if32.busy : if16.busy;
    endfunction

    function automatic bit done_of(input int k);
        return (k == 0) ? if32.done : if16.done;
    endfunction

    function automatic bit neg_of(input int k);
        return (k == 0) ? if32.neg : if16.neg;
    endfunction

    function automatic bit ovf_of(input int k);
        return (k == 0) ? if32.overflow : if16.overflow;
    endfunction

    function automatic logic [63:0] bcd_of(input int k);
        return (k == 0) ? 64'(if32.bcd) : 64'(if16.bcd);
    endfunction

    function automatic logic [63:0] en_of(input int k);
        return (k == 0) ? 64'(if32.en) : 64'(if16.en);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Plain decimal arithmetic: magnitude, saturation, digit split, blanking.
    task automatic ref_convert(input logic [63:0] b, input int bw, input int nd, input bit sm,
                               output logic [63:0] bcd, output logic [63:0] en,
                               output bit neg, output bit ovf);
        longint unsigned mag, lim, v;
        int top;
        mag = b & mask_of(bw);
        neg = sm && b[bw-1];
        if (neg) mag = (64'd1 << bw) - mag;
        lim = 1;
        for (int i = 0; i < nd; i++) lim = lim * 10;
        ovf = (mag >= lim);
        bcd = '0;
        en  = '0;
        if (ovf) begin
            for (int i = 0; i < nd; i++) begin
                bcd[4*i +: 4] = 4'h9;
                en[i] = 1'b1;
            end
        end else begin
            v   = mag;
            top = 0;
            for (int i = 0; i < nd; i++) begin
                bcd[4*i +: 4] = 4'(v % 10);
                if ((v % 10) != 0) top = i;
                v = v / 10;
            end
            for (int i = 0; i <= top; i++) en[i] = 1'b1;
        end
    endtask

    task automatic kick(input int k, input logic [63:0] b, input bit sm);
        if (k == 0) begin
            if32.start = 1'b1; if32.bin = b[31:0]; if32.signed_mode = sm;
        end else begin
            if16.start = 1'b1; if16.bin = b[15:0]; if16.signed_mode = sm;
        end
    endtask

    task automatic drop_start(input int k);
        if (k == 0) if32.start = 1'b0;
        else        if16.start = 1'b0;
    endtask

    // Counts edges after the accepting edge until done is seen (bounded).
    task automatic wait_done(input int k, output int edges);
        edges = 0;
        while (!done_of(k) && edges < 200) begin
            @(posedge clk_100kHz); #1;
            edges++;
        end
    endtask

    task automatic go(input int k, input logic [63:0] b, input bit sm, output int edges);
        @(posedge clk_100kHz); #1;
        kick(k, b, sm);
        @(posedge clk_100kHz); #1;
        drop_start(k);
        wait_done(k, edges);
    endtask

    function automatic logic [63:0] pick_val(input int bw);
        logic [63:0] v;
        case ($urandom_range(0, 7))
            0:       v = '0;
            1:       v = '1;
            2:       v = 64'd1 << (bw - 1);
            3:       v = 64'd9999;
            4:       v = 64'd10000;
            5:       v = 64'($urandom_range(0, 999));
            6:       v = -(64'd9999 + 64'($urandom_range(0, 1)));
            default: v = {$urandom, $urandom};
        endcase
        return v & mask_of(bw);
    endfunction

    // Model: advances on each rising edge from the inputs presented to it.
    initial begin
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_done[k] = 1'b0; m_bcd[k] = '0; m_en[k] = 64'd1;
            m_neg[k] = 1'b0; m_ovf[k] = 1'b0;
        end
        forever begin
            @(posedge clk_100kHz);
            for (int k = 0; k < 2; k++) begin
                logic [63:0] b;
                bit          st, sm;
                if (k == 0) begin
                    st = if32.start; b = 64'(if32.bin); sm = if32.signed_mode;
                end else begin
                    st = if16.start; b = 64'(if16.bin); sm = if16.signed_mode;
                end
                m_done[k] = 1'b0;
                if (!rst_) begin
                    m_cnt[k] = 0; m_bcd[k] = '0; m_en[k] = 64'd1;
                    m_neg[k] = 1'b0; m_ovf[k] = 1'b0;
                end else if (m_cnt[k] > 0) begin
                    m_cnt[k]--;
                    if (m_cnt[k] == 0) begin
                        m_done[k] = 1'b1;
                        m_bcd[k] = m_pbcd[k]; m_en[k] = m_pen[k];
                        m_neg[k] = m_pneg[k]; m_ovf[k] = m_povf[k];
                    end
                end else if (st) begin
                    m_cnt[k] = bw_of(k) + 1;
                    ref_convert(b, bw_of(k), nd_of(k), sm, m_pbcd[k], m_pen[k], m_pneg[k], m_povf[k]);
                end
            end
            model_live = 1'b1;
        end
    end

    // Compare: every falling edge, both instances, all outputs.
    initial forever begin
        @(negedge clk_100kHz);
        if (model_live) begin
            for (int k = 0; k < 2; k++) begin
                logic [63:0] st_act, st_exp;
                st_act = {60'd0, busy_of(k), done_of(k), neg_of(k), ovf_of(k)};
                st_exp = {60'd0, (m_cnt[k] > 0), m_done[k], m_neg[k], m_ovf[k]};
                check($sformatf("dut%0d busy/done/neg/ovf", k), st_act, st_exp);
                check($sformatf("dut%0d bcd", k), bcd_of(k), m_bcd[k]);
                check($sformatf("dut%0d en", k), en_of(k), m_en[k]);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int edges, ndone;
        if32.start = 1'b0; if32.bin = '0; if32.signed_mode = 1'b0;
        if16.start = 1'b0; if16.bin = '0; if16.signed_mode = 1'b0;
        rst_ = 1'b0;
        repeat (3) @(posedge clk_100kHz);
        #1;
        check("reset busy32", 64'(if32.busy), 64'd0);
        check("reset done32", 64'(if32.done), 64'd0);
        check("reset bcd32", 64'(if32.bcd), 64'd0);
        check("reset en32", 64'(if32.en), 64'd1);
        check("reset neg/ovf32", 64'({if32.neg, if32.overflow}), 64'd0);
        rst_ = 1'b1;

        go(0, 64'd0, 1'b0, edges);
        check("zero latency", 64'(edges), 64'd33);
        check("zero bcd", 64'(if32.bcd), 64'd0);
        check("zero en", 64'(if32.en), 64'b1);
        check("zero neg/ovf", 64'({if32.neg, if32.overflow}), 64'd0);

        go(0, 64'hFFFF_FFFF, 1'b0, edges);
        check("umax bcd", 64'(if32.bcd), 64'h42_9496_7295);
        check("umax en", 64'(if32.en), 64'h3FF);
        check("umax ovf", 64'(if32.overflow), 64'd0);

        go(0, 64'hFFFF_FF85, 1'b1, edges);
        check("m123 bcd", 64'(if32.bcd), 64'h123);
        check("m123 en", 64'(if32.en), 64'b111);
        check("m123 neg", 64'(if32.neg), 64'd1);

        go(0, 64'h8000_0000, 1'b1, edges);
        check("smin bcd", 64'(if32.bcd), 64'h21_4748_3648);
        check("smin neg", 64'(if32.neg), 64'd1);

        // Still in the done cycle: a new start here must be taken at once.
        kick(0, 64'd1234567, 1'b0);
        @(posedge clk_100kHz); #1;
        drop_start(0);
        wait_done(0, edges);
        check("b2b latency", 64'(edges), 64'd33);
        check("b2b bcd", 64'(if32.bcd), 64'h123_4567);

        // Second start while busy is dropped, not queued.
        @(posedge clk_100kHz); #1;
        kick(0, 64'd7654321, 1'b0);
        @(posedge clk_100kHz); #1;
        drop_start(0);
        repeat (10) begin @(posedge clk_100kHz); #1; end
        kick(0, 64'd42, 1'b0);
        @(posedge clk_100kHz); #1;
        drop_start(0);
        wait_done(0, edges);
        check("busy-start latency", 64'(edges + 11), 64'd33);
        check("busy-start bcd", 64'(if32.bcd), 64'h765_4321);
        ndone = 0;
        repeat (40) begin @(posedge clk_100kHz); #1; if (if32.done) ndone++; end
        check("busy-start no extra done", 64'(ndone), 64'd0);

        // Reset part way through a conversion.
        kick(0, 64'd555, 1'b0);
        @(posedge clk_100kHz); #1;
        drop_start(0);
        repeat (10) begin @(posedge clk_100kHz); #1; end
        rst_ = 1'b0;
        @(posedge clk_100kHz); #1;
        check("abort busy", 64'(if32.busy), 64'd0);
        check("abort bcd", 64'(if32.bcd), 64'd0);
        check("abort en", 64'(if32.en), 64'd1);
        check("abort neg/ovf", 64'({if32.neg, if32.overflow}), 64'd0);
        rst_ = 1'b1;
        ndone = 0;
        repeat (40) begin @(posedge clk_100kHz); #1; if (if32.done) ndone++; end
        check("abort no done", 64'(ndone), 64'd0);

        go(1, 64'd12345, 1'b0, edges);
        check("d4 latency", 64'(edges), 64'd17);
        check("d4 12345 ovf", 64'(if16.overflow), 64'd1);
        check("d4 12345 bcd", 64'(if16.bcd), 64'h9999);
        check("d4 12345 en", 64'(if16.en), 64'hF);
        go(1, 64'd9999, 1'b0, edges);
        check("d4 9999 ovf", 64'(if16.overflow), 64'd0);
        check("d4 9999 bcd", 64'(if16.bcd), 64'h9999);
        go(1, 64'd10000, 1'b0, edges);
        check("d4 10000 ovf", 64'(if16.overflow), 64'd1);
        go(1, 64'hFFFF, 1'b1, edges);
        check("d4 m1 bcd", 64'(if16.bcd), 64'h1);
        check("d4 m1 neg/en", 64'({if16.neg, if16.en}), 64'h11);

        // Random traffic on both instances, including starts while busy,
        // inputs changing mid-conversion and occasional resets.
        repeat (4000) begin
            @(posedge clk_100kHz); #1;
            rst_ = ($urandom_range(0, 599) != 0);
            for (int k = 0; k < 2; k++) begin
                kick(k, pick_val(bw_of(k)), 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 2) != 0) drop_start(k);
            end
        end
        @(posedge clk_100kHz); #1;
        rst_ = 1'b1;
        drop_start(0);
        drop_start(1);
        repeat (40) @(posedge clk_100kHz);
        @(negedge clk_100kHz);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Parametrised, multi-cycle binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock. It serves the display path: it takes a binary count or measurement, registers a packed BCD result, and produces a per-digit leading-zero blanking mask for the 7-segment scanner. Compared with the single-cycle converter, it adds configurable input and digit widths, a signed mode, overflow saturation, and a start/busy/done handshake. The handshake lets the shift loop be serial instead of unrolled.

Parameters:
- BIN_W, 32: binary input width in bits, 2..64.
- DIGITS, 10: number of BCD digits produced, 1..20.
- CNT_W, $clog2(BIN_W+1): width of the shift counter. Derived; not overridden.

Ports:
- clk_100kHz  input  1  system clock; all logic on the rising edge.
- rst_  input  1  reset; synchronous, active-low.
- start  input  1  conversion request; sampled only while busy=0.
- signed_mode  input  1  when 1, bin is two's complement; sampled with start.
- bin  input  BIN_W  value to convert; sampled with start.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when new results are valid.
- bcd  output  4*DIGITS  packed digits; bcd[3:0] is units, bcd[4*DIGITS-1 -: 4] is the most significant digit.
- en  output  DIGITS  digit enable mask; en[i] enables digit i; en[0] is always 1.
- neg  output  1  result is negative; the display shows a minus sign.
- overflow  output  1  magnitude exceeds 10^DIGITS-1.

Behaviour:
- Reset (rst_=0 at a rising edge):
  - State goes to IDLE. busy=0, done=0, bcd=0, en=1 (units digit only), neg=0, overflow=0.
  - Internal shift and BCD registers are cleared.
  - Reset during SHIFT aborts the conversion; no done is issued.
- States:
  - IDLE: busy=0.
  - SHIFT: busy=1.
  - There is no separate DONE state.
- IDLE → SHIFT, at the edge where start=1:
  - The magnitude is loaded into the shift register. mag = (signed_mode && bin[BIN_W-1]) ? (~bin + 1) : bin, computed at BIN_W bits unsigned. For -2^(BIN_W-1) this gives 2^(BIN_W-1), which is correct unsigned.
  - The neg flag is latched internally. A zero input never sets neg.
  - The BCD accumulator is cleared, the overflow sticky bit is cleared, and cnt is set to BIN_W.
- SHIFT, each edge:
  - Every accumulator digit >= 5 has 3 added (mod 16).
  - The {accumulator, mag} pair is then shifted left by 1.
  - If the bit shifted out of the accumulator MSB is 1, the overflow sticky bit is set.
  - cnt decrements by 1.
- SHIFT → IDLE, at the edge where cnt reaches 0 (i.e. BIN_W shift edges after load):
  - bcd, en, neg and overflow are registered from the final accumulator.
  - done=1 for exactly that cycle; busy=0 from that cycle on.
  - Latency: done rises BIN_W+1 edges after the edge that accepted start.
- Overflow: when sticky=1, or when any shift would exceed 4*DIGITS bits, then overflow=1, every bcd digit=9 and en all ones.
- Enable mask: en[i]=1 for i=0..k, where k is the index of the most significant nonzero digit (k=0 if the value is 0). All higher bits are 0.
- Hold: bcd, en, neg and overflow hold their values between done pulses. They do not change during SHIFT.
- start while busy=1 is ignored; it is not queued.
- start in the same cycle as done (busy=0) is accepted, giving a back-to-back conversion.
- bin and signed_mode changing during SHIFT have no effect.

Test Plan:
1. BIN_W=32, DIGITS=10, bin=0, start for one cycle → done exactly 33 edges after start; bcd=0, en=10'b0000000001, neg=0, overflow=0.
2. bin=32'hFFFFFFFF, signed_mode=0 → digits 4,2,9,4,9,6,7,2,9,5 (MS→LS), en=10'h3FF, overflow=0.
3. signed_mode=1, bin=32'hFFFFFF85 → neg=1, bcd=123, en=10'b0000000111.
4. signed_mode=1, bin=32'h80000000 → neg=1, bcd=2147483648.
5. DIGITS=4 instance, bin=12345 → overflow=1, bcd=16'h9999, en=4'hF. Then bin=9999 → overflow=0, bcd=16'h9999.
6. Handshake and reset:
   - start pulsed again mid-SHIFT → ignored, single done, result from the first bin.
   - start asserted on the done cycle → second done 33 edges later.
   - rst_=0 at shift 10 → busy=0, all outputs at reset values, no done.
